rram_pulse_ctrl: RTL and testbench

Sequencer for the RRAM test structures: the 1T1R cell (TE, WL, four SL devices 036/100/300/700) and the bare 1R cell.
- Accepts one command at a time (READ, SET, RESET, FORM) over a valid/ready handshake.
- Generates cycle-exact, non-overlapping enables for the analog switch fabric: select, then pulse, then discharge.
- Samples the external sense comparator for READ, through a synchronizer.
- Sits between the Wishbone/logic-analyzer register block and the pad-side analog switches.

---
 rtl/rram_pulse_ctrl_if.sv | 22 ++
 rtl/rram_pulse_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_rram_pulse_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rram_pulse_ctrl_if.sv
// Command channel of the RRAM pulse sequencer: valid/ready handshake plus abort.
// The register block drives the master side; the sequencer takes the slave side.
interface rram_pulse_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [2:0]       cmd_sel;
  logic [CNT_W-1:0] cmd_width;
  logic             abort;

  modport master (
    output cmd_valid, cmd_op, cmd_sel, cmd_width, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_sel, cmd_width, abort,
    output cmd_ready
  );
endinterface

// File: rtl/rram_pulse_ctrl.sv
// Select -> pulse -> discharge sequencer for the 1T1R and 1R RRAM test cells.
// Every pad-side enable is a flop loaded from the next-state decode, so no enable glitches.
module rram_pulse_ctrl #(
  parameter int CNT_W     = 16,
  parameter int SETUP_CYC = 4,
  parameter int HOLD_CYC  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  rram_pulse_ctrl_if.slave cmd,
  output logic [3:0]       sl_sel,
  output logic             r1_sel,
  output logic             wl_en,
  output logic             wl_boost,
  output logic             te_drv,
  output logic             sl_drv,
  output logic             read_en,
  input  logic             sense_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             aborted,
  output logic             rd_data,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_DONE} state_t;

  localparam logic [1:0]       OP_READ  = 2'd0;
  localparam logic [1:0]       OP_SET   = 2'd1;
  localparam logic [1:0]       OP_RESET = 2'd2;
  localparam logic [1:0]       OP_FORM  = 2'd3;
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  state_t           r_state, w_state_next;
  logic [1:0]       r_op, w_op_next;
  logic [2:0]       r_sel, w_sel_next;
  logic [CNT_W-1:0] r_width, w_width_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_abt, w_abt_next;
  logic             r_err, w_err_next;
  logic             r_aborted, w_aborted_next;
  logic             r_rd_data, w_rd_next;
  logic [CNT_W-1:0] r_op_count, w_count_next;
  logic             r_sync1, r_sync2;

  logic [3:0]       r_sl_sel, w_sl_sel_next;
  logic             r_r1_sel, w_r1_next;
  logic             r_wl_en, w_wl_next;
  logic             r_wl_boost, w_boost_next;
  logic             r_te_drv, w_te_next;
  logic             r_sl_drv, w_sl_next;
  logic             r_read_en, w_read_next;
  logic             r_done, w_done_next;

  logic             w_accept;
  logic             w_legal;
  logic [CNT_W-1:0] w_pulse_ld;

  assign w_accept   = cmd.cmd_valid && (r_state == S_IDLE);
  assign w_legal    = (cmd.cmd_sel <= 3'd4);
  assign w_pulse_ld = (r_width == '0) ? '0 : r_width - 1'b1;

  always_comb begin
    w_state_next   = r_state;
    w_op_next      = r_op;
    w_sel_next     = r_sel;
    w_width_next   = r_width;
    w_cnt_next     = r_cnt;
    w_abt_next     = r_abt;
    w_err_next     = r_err;
    w_aborted_next = r_aborted;
    w_rd_next      = r_rd_data;
    w_count_next   = r_op_count;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_op_next      = cmd.cmd_op;
          w_sel_next     = cmd.cmd_sel;
          w_width_next   = cmd.cmd_width;
          w_abt_next     = 1'b0;
          w_aborted_next = 1'b0;
          if (w_legal) begin
            w_err_next   = 1'b0;
            w_cnt_next   = SETUP_LD;
            w_state_next = S_SETUP;
          end else begin
            w_err_next   = 1'b1;
            w_state_next = S_DONE;
          end
        end
      end
      S_SETUP: begin
        if (cmd.abort) begin
          w_abt_next   = 1'b1;
          w_cnt_next   = HOLD_LD;
          w_state_next = S_HOLD;
        end else if (r_cnt == '0) begin
          w_cnt_next   = w_pulse_ld;
          w_state_next = S_PULSE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_PULSE: begin
        if (cmd.abort) begin
          w_abt_next   = 1'b1;
          w_cnt_next   = HOLD_LD;
          w_state_next = S_HOLD;
        end else if (r_cnt == '0) begin
          // Sense result is captured only when the pulse ran to completion.
          if (r_op == OP_READ) w_rd_next = r_sync2;
          w_cnt_next   = HOLD_LD;
          w_state_next = S_HOLD;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_aborted_next = r_abt;
          if (!r_abt) w_count_next = r_op_count + 1'b1;
          w_state_next = S_DONE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Enables are decoded from the state being entered so they line up with it.
  always_comb begin
    w_sl_sel_next = '0;
    w_r1_next     = 1'b0;
    w_wl_next     = 1'b0;
    w_boost_next  = 1'b0;
    w_te_next     = 1'b0;
    w_sl_next     = 1'b0;
    w_read_next   = 1'b0;
    w_done_next   = (w_state_next == S_DONE);
    if (w_state_next == S_SETUP || w_state_next == S_PULSE || w_state_next == S_HOLD) begin
      if (w_sel_next < 3'd4)       w_sl_sel_next[w_sel_next[1:0]] = 1'b1;
      else if (w_sel_next == 3'd4) w_r1_next = 1'b1;
    end
    if (w_state_next == S_PULSE) begin
      w_wl_next = (w_sel_next < 3'd4);
      case (w_op_next)
        OP_READ:  w_read_next = 1'b1;
        OP_SET:   w_te_next   = 1'b1;
        OP_RESET: w_sl_next   = 1'b1;
        OP_FORM: begin
          w_te_next    = 1'b1;
          w_boost_next = (w_sel_next < 3'd4);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_sel      <= '0;
      r_width    <= '0;
      r_cnt      <= '0;
      r_abt      <= 1'b0;
      r_err      <= 1'b0;
      r_aborted  <= 1'b0;
      r_rd_data  <= 1'b0;
      r_op_count <= '0;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_sl_sel   <= '0;
      r_r1_sel   <= 1'b0;
      r_wl_en    <= 1'b0;
      r_wl_boost <= 1'b0;
      r_te_drv   <= 1'b0;
      r_sl_drv   <= 1'b0;
      r_read_en  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_op       <= w_op_next;
      r_sel      <= w_sel_next;
      r_width    <= w_width_next;
      r_cnt      <= w_cnt_next;
      r_abt      <= w_abt_next;
      r_err      <= w_err_next;
      r_aborted  <= w_aborted_next;
      r_rd_data  <= w_rd_next;
      r_op_count <= w_count_next;
      r_sync1    <= sense_in;
      r_sync2    <= r_sync1;
      r_sl_sel   <= w_sl_sel_next;
      r_r1_sel   <= w_r1_next;
      r_wl_en    <= w_wl_next;
      r_wl_boost <= w_boost_next;
      r_te_drv   <= w_te_next;
      r_sl_drv   <= w_sl_next;
      r_read_en  <= w_read_next;
      r_done     <= w_done_next;
    end
  end

  assign cmd.cmd_ready = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign sl_sel        = r_sl_sel;
  assign r1_sel        = r_r1_sel;
  assign wl_en         = r_wl_en;
  assign wl_boost      = r_wl_boost;
  assign te_drv        = r_te_drv;
  assign sl_drv        = r_sl_drv;
  assign read_en       = r_read_en;
  assign done          = r_done;
  assign err           = r_err;
  assign aborted       = r_aborted;
  assign rd_data       = r_rd_data;
  assign op_count      = r_op_count;

endmodule

// File: tb/tb_rram_pulse_ctrl.sv
// Bench for rram_pulse_ctrl: directed table, hand-written reset/back-to-back sequences,
// and random commands checked cycle by cycle against a phase-timing model.
module tb_rram_pulse_ctrl;
  localparam int S = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  sl_sel;
  logic        r1_sel, wl_en, wl_boost, te_drv, sl_drv, read_en;
  logic        sense_in = 1'b0;
  logic        busy, done, err, aborted, rd_data;
  logic [15:0] op_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_count = '0;
  logic        m_rd = 1'b0;
  logic        m_err = 1'b0;

  rram_pulse_ctrl_if #(.CNT_W(16)) cif ();

  rram_pulse_ctrl #(.CNT_W(16), .SETUP_CYC(S), .HOLD_CYC(H)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .cmd      (cif),
    .sl_sel   (sl_sel),
    .r1_sel   (r1_sel),
    .wl_en    (wl_en),
    .wl_boost (wl_boost),
    .te_drv   (te_drv),
    .sl_drv   (sl_drv),
    .read_en  (read_en),
    .sense_in (sense_in),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .aborted  (aborted),
    .rd_data  (rd_data),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // te_drv and sl_drv may never be driven together, whatever the scenario.
  always @(negedge clk) begin
    checks++;
    if (te_drv && sl_drv) begin
      errors++;
      $display("FAIL te_sl_overlap: got te=1 sl=1 expected not both");
    end
  end

  function automatic logic [12:0] out_vec();
    return {sl_sel, r1_sel, wl_en, wl_boost, te_drv, sl_drv, read_en, done, busy, cif.cmd_ready};
  endfunction

  // Runs one command from an idle negedge; cycle c=0 is the cycle after the accept edge.
  // abort_at: -1 none, -2 asserted together with cmd_valid, else raised during cycle abort_at.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [2:0] sel,
                        input int width, input logic sense, input int abort_at,
                        input bit keep, output int done_seen);
    int W, end_drv, done_c;
    bit legal, ab, sel_on, pulse;
    logic [3:0]  e_sl;
    logic        e_wl;
    logic [12:0] exp;
    W = (width == 0) ? 1 : width;
    legal = (sel <= 3'd4);
    ab = legal && (abort_at >= 0) && (abort_at < S + W);
    end_drv = !legal ? 0 : (ab ? abort_at + 1 : S + W);
    done_c  = !legal ? 0 : end_drv + H;
    sense_in = sense;
    cif.cmd_op = op;
    cif.cmd_sel = sel;
    cif.cmd_width = 16'(width);
    cif.cmd_valid = 1'b1;
    cif.abort = (abort_at == -2);
    check({tag, " ready"}, {31'd0, cif.cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (!keep) cif.cmd_valid = 1'b0;
    cif.abort = 1'b0;
    done_seen = -1;
    for (int c = 0; c <= done_c; c++) begin
      @(negedge clk);
      sel_on = legal && (c < done_c);
      pulse  = legal && (c >= S) && (c < end_drv);
      e_sl = (sel_on && sel < 3'd4) ? (4'b0001 << sel[1:0]) : 4'b0000;
      e_wl = pulse && (sel < 3'd4);
      exp = {e_sl, sel_on && (sel == 3'd4), e_wl, e_wl && (op == 2'd3),
             pulse && (op == 2'd1 || op == 2'd3), pulse && (op == 2'd2),
             pulse && (op == 2'd0), c == done_c, 1'b1, 1'b0};
      check($sformatf("%s cyc%0d outputs", tag, c), {19'd0, out_vec()}, {19'd0, exp});
      if (done && done_seen < 0) done_seen = c;
      if (c == done_c) begin
        if (legal) begin
          m_err = 1'b0;
          if (!ab) begin
            m_count = m_count + 16'd1;
            if (op == 2'd0) m_rd = sense;
          end
        end else begin
          m_err = 1'b1;
        end
        check({tag, " err"}, {31'd0, err}, {31'd0, m_err});
        check({tag, " aborted"}, {31'd0, aborted}, {31'd0, ab});
        check({tag, " rd_data"}, {31'd0, rd_data}, {31'd0, m_rd});
        check({tag, " op_count"}, {16'd0, op_count}, {16'd0, m_count});
      end
      cif.abort = (c == abort_at);
    end
    @(negedge clk);
    cif.abort = 1'b0;
    check({tag, " idle"}, {19'd0, out_vec()}, 32'd1);
    $display("txn %s op=%0d sel=%0d width=%0d abort_at=%0d done_cycle=%0d op_count=%0d",
             tag, op, sel, width, abort_at, done_seen, op_count);
  endtask

  typedef struct {
    string      name;
    logic [1:0] op;
    logic [2:0] sel;
    int         width;
    logic       sense;
    int         abort_at;
    bit         keep;
    int         exp_lat;
  } vec_t;

  vec_t vecs[12];
  int   lat;

  initial begin
    vecs[0]  = '{"set_w10",        2'd1, 3'd1, 10, 1'b0, -1, 1'b0, 18};
    vecs[1]  = '{"read_1r_s1",     2'd0, 3'd4,  6, 1'b1, -1, 1'b0, 14};
    vecs[2]  = '{"read_1r_s0",     2'd0, 3'd4,  6, 1'b0, -1, 1'b0, 14};
    vecs[3]  = '{"read_1r_s1b",    2'd0, 3'd4,  6, 1'b1, -1, 1'b0, 14};
    vecs[4]  = '{"reset_w0",       2'd2, 3'd0,  0, 1'b0, -1, 1'b0,  9};
    vecs[5]  = '{"form_abort",     2'd3, 3'd3, 20, 1'b0,  8, 1'b0, 13};
    vecs[6]  = '{"illegal_sel6",   2'd1, 3'd6,  5, 1'b0, -1, 1'b0,  0};
    vecs[7]  = '{"set_clears_err", 2'd1, 3'd2,  3, 1'b0, -1, 1'b0, 11};
    vecs[8]  = '{"read_idle_abt",  2'd0, 3'd0,  2, 1'b0, -2, 1'b0, 10};
    vecs[9]  = '{"b2b_first",      2'd1, 3'd0,  2, 1'b0, -1, 1'b1, 10};
    vecs[10] = '{"b2b_second",     2'd2, 3'd1,  1, 1'b0, -1, 1'b0,  9};
    vecs[11] = '{"abort_setup",    2'd0, 3'd1,  5, 1'b1,  1, 1'b0,  6};

    cif.cmd_valid = 1'b0;
    cif.cmd_op = '0;
    cif.cmd_sel = '0;
    cif.cmd_width = '0;
    cif.abort = 1'b0;
    repeat (3) @(negedge clk);
    check("reset outputs", {19'd0, out_vec()}, 32'd1);
    check("reset status", {28'd0, err, aborted, rd_data, busy}, 32'd0);
    check("reset op_count", {16'd0, op_count}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].sel, vecs[i].width, vecs[i].sense,
             vecs[i].abort_at, vecs[i].keep, lat);
      check({vecs[i].name, " latency"}, lat, vecs[i].exp_lat);
    end

    // Abort raised during HOLD must be ignored.
    run_op("abort_in_hold", 2'd1, 3'd2, 2, 1'b0, 7, 1'b0, lat);
    check("abort_in_hold latency", lat, 32'd10);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      logic [2:0] sel;
      int w, ab;
      op  = 2'($urandom_range(0, 3));
      sel = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      w   = $urandom_range(0, 12);
      case ($urandom_range(0, 3))
        0:       ab = $urandom_range(0, S + w + H);
        1:       ab = -2;
        default: ab = -1;
      endcase
      run_op($sformatf("rand%0d", i), op, sel, w, 1'($urandom_range(0, 1)), ab, 1'($urandom_range(0, 1)), lat);
    end
    cif.cmd_valid = 1'b0;
    @(negedge clk);

    // Make rd_data 1, then yank reset in the middle of a SET pulse.
    run_op("read_before_rst", 2'd0, 3'd0, 3, 1'b1, -1, 1'b0, lat);
    cif.cmd_op = 2'd1;
    cif.cmd_sel = 3'd0;
    cif.cmd_width = 16'd10;
    cif.cmd_valid = 1'b1;
    @(posedge clk);
    #1 cif.cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_reset te_drv", {31'd0, te_drv}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("midop_reset outputs", {19'd0, out_vec()}, 32'd1);
    check("midop_reset status", {28'd0, err, aborted, rd_data, busy}, 32'd0);
    check("midop_reset op_count", {16'd0, op_count}, 32'd0);
    m_count = '0;
    m_rd = 1'b0;
    m_err = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_op("after_reset", 2'd1, 3'd3, 4, 1'b0, -1, 1'b0, lat);
    check("after_reset latency", lat, 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
